// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: multi-read, dual-write register file with write bypass
// and a per-register pending scoreboard for RAW/WAW hazard detection.
module rf_multiport_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wa_we_i,
   input  logic [ADDR_W-1:0]        wa_addr_i,
   input  logic [DATA_W-1:0]        wa_data_i,
   input  logic                     wb_we_i,
   input  logic [ADDR_W-1:0]        wb_addr_i,
   input  logic [DATA_W-1:0]        wb_data_i,
   input  logic                     iss_valid_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   output logic                     iss_ready_o,
   output logic [ADDR_W:0]          pend_cnt_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wa_en, wb_en, iss_acc;

   // writes to a hardwired r0 are dropped here so they never store, clear or bypass
   assign wa_en = wa_we_i & ~(ZERO_REG != 0 && wa_addr_i == '0);
   assign wb_en = wb_we_i & ~(ZERO_REG != 0 && wb_addr_i == '0);
   assign iss_ready_o = ~pend_q[iss_addr_i] | (wa_en && wa_addr_i == iss_addr_i)
                      | (wb_en && wb_addr_i == iss_addr_i);
   assign iss_acc = iss_valid_i & iss_ready_o & ~(ZERO_REG != 0 && iss_addr_i == '0);
   assign pend_cnt_o = cnt_q;

   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (wa_en) begin
         regs_d[wa_addr_i] = wa_data_i;
         pend_d[wa_addr_i] = 1'b0;
      end
      if (wb_en) begin
         regs_d[wb_addr_i] = wb_data_i;
         pend_d[wb_addr_i] = 1'b0;
      end
      if (iss_acc) pend_d[iss_addr_i] = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q <= '{default: '0};
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              z, ha, hb;
      assign a  = rd_addr_i[k*ADDR_W +: ADDR_W];
      assign z  = ZERO_REG != 0 && a == '0;
      assign ha = BYPASS != 0 && rst_ni && wa_en && wa_addr_i == a;
      assign hb = BYPASS != 0 && rst_ni && wb_en && wb_addr_i == a;
      assign rd_data_o[k*DATA_W +: DATA_W] = z ? '0 : hb ? wb_data_i : ha ? wa_data_i : regs_q[a];
      assign rd_busy_o[k] = pend_q[a] & ~ha & ~hb & ~z;
   end
endmodule
